// File: rtl/life_engine.sv
// Parametrised Game-of-Life engine: ROWS x COLS grid with run/pause/step control, seed load and stable/extinct flags.
// Optional macro LIFE_HALT_ON_STABLE_EN: a RUN generation that is stable or extinct stops the engine in HALT.
`timescale 1ns/1ps

module life_engine #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int TICK_DIV = 12500000,
  parameter int WRAP     = 0,
  parameter int GEN_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [ROWS*COLS-1:0] seed,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 step,
  output logic [ROWS*COLS-1:0] grid,
  output logic [GEN_W-1:0]     gen_count,
  output logic [1:0]           state,
  output logic                 stable,
  output logic                 extinct
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     tick_cnt;
  logic                 tick;
  logic                 do_load, do_gen, clr_stable;
  logic [ROWS*COLS-1:0] next_grid;
  logic                 next_same, next_dead;

  // Neighbour k (0..7) enumerates the 3x3 window in raster order, skipping the centre.
  function automatic int nb_dr(input int k);
    return ((k < 4) ? k : k + 1) / 3 - 1;
  endfunction

  function automatic int nb_dc(input int k);
    return ((k < 4) ? k : k + 1) % 3 - 1;
  endfunction

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [7:0] nb;
      logic [3:0] n;

      for (genvar k = 0; k < 8; k++) begin : g_nb
        localparam int RR = r + nb_dr(k);
        localparam int CC = c + nb_dc(k);
        if (WRAP != 0) begin : g_wrap
          assign nb[k] = grid[((RR + ROWS) % ROWS) * COLS + ((CC + COLS) % COLS)];
        end else if (RR < 0 || RR >= ROWS || CC < 0 || CC >= COLS) begin : g_edge
          assign nb[k] = 1'b0;
        end else begin : g_inner
          assign nb[k] = grid[RR * COLS + CC];
        end
      end

      assign n = 4'($countones(nb));
      assign next_grid[r*COLS+c] = (n == 4'd3) || (grid[r*COLS+c] && (n == 4'd2));
    end
  end

  assign next_same = (next_grid == grid);
  assign next_dead = (next_grid == '0);
  assign tick      = (state_q == S_RUN) && (tick_cnt == CNT_W'(TICK_DIV - 1));
  assign state     = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Control priority: load > pause > start > step; a tick only acts when no control input claims the edge.
  always_comb begin
    // NOTE: every output of this block gets a default first, otherwise the
    // paths that do not assign it would infer a latch.
    state_d    = state_q;
    do_load    = 1'b0;
    do_gen     = 1'b0;
    clr_stable = 1'b0;
    if (load) begin
      do_load = 1'b1;
      state_d = S_PAUSE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) state_d = S_RUN;
        end
        S_RUN: begin
          if (pause) begin
            state_d = S_PAUSE;
          end else if (tick) begin
            do_gen = 1'b1;
`ifdef LIFE_HALT_ON_STABLE_EN
            if (next_same || next_dead) state_d = S_HALT;
`endif
          end
        end
        S_PAUSE: begin
          if (pause)      state_d = S_PAUSE;
          else if (start) state_d = S_RUN;
          else if (step)  do_gen  = 1'b1;
        end
        S_HALT: begin
          if (start) begin
            state_d    = S_RUN;
            clr_stable = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // The tick counter only advances while staying in RUN; entering RUN restarts it at zero.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!reset)                                     tick_cnt <= '0;
    else if (state_q != S_RUN || state_d != S_RUN)  tick_cnt <= '0;
    else if (tick)                                  tick_cnt <= '0;
    else                                            tick_cnt <= tick_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the grid is a flop array, not a RAM, so it is reset like any other
    // register; the LED driver must never see power-up garbage.
    if (!reset) begin
      grid      <= '0;
      gen_count <= '0;
      stable    <= 1'b0;
      extinct   <= 1'b0;
    end else if (do_load) begin
      grid      <= seed;
      gen_count <= '0;
      stable    <= 1'b0;
      extinct   <= (seed == '0);
    end else if (do_gen) begin
      grid      <= next_grid;
      if (gen_count != '1) gen_count <= gen_count + 1'b1;
      stable    <= next_same;
      extinct   <= next_dead;
    end else if (clr_stable) begin
      stable    <= 1'b0;
    end
  end

endmodule
